fifo_pkt_drain: RTL
===================

# fifo_pkt_drain

Downstream consumer of the FIFO selection stage. Takes the 8-bit selection code `fifo_sel_res_final` (bit 7 = valid, low bits = FIFO index), locks onto the chosen input FIFO, and forwards exactly one length-framed packet from it to a single output stream with valid/ready backpressure. It then releases the port and waits for the next selection. It sits between the per-port input FIFOs (first-word-fall-through) and the shared output link.

## Interface
- `PORT_NUM`, 4: number of input FIFOs; legal 1..128.
- `DATA_W`, 32: FIFO and output word width; must be ≥ 8.
- `glb_clk`  in  1  single clock; all logic on rising edge.
- `glb_reset`  in  1  reset, synchronous, active-high.
- `fifo_sel_res_final`  in  8  selection code: [7] = valid, [6:0] = FIFO index.
- `fifo_empty`  in  PORT_NUM  per-FIFO empty flag; FWFT, so `fifo_dout` slice is valid when empty=0.
- `fifo_dout`  in  PORT_NUM*DATA_W  concatenated FIFO heads; port i = bits [i*DATA_W +: DATA_W].
- `fifo_rd_en`  out  PORT_NUM  one-hot pop strobe; at most one bit high.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  DATA_W  output word.
- `out_sop`  out  1  word is a packet header.
- `out_eop`  out  1  word is the last of the packet.
- `busy`  out  1  a packet is in progress (state ≠ IDLE).
- `cur_port`  out  7  index of the locked FIFO; holds its last value after the packet.
- `pkt_done`  out  1  one-cycle pulse after the eop beat is accepted.
- `sel_err`  out  1  one-cycle pulse when a valid code carries index ≥ PORT_NUM.
- `pkt_count`  out  16  count of packets forwarded; wraps modulo 2^16.

## Operation
- Packet format: word 0 is the header, and header[7:0] = N, the number of payload words that follow (0..255). Total beats = N+1.
- A beat transfers when `out_valid & out_ready`. On that cycle `fifo_rd_en[cur_port]`=1; otherwise all `fifo_rd_en`=0.
- States:
  - IDLE
    - If sel[7]=1, index < PORT_NUM and `fifo_empty[index]`=0: latch `cur_port`=index, go to HDR.
    - If sel[7]=1 and index ≥ PORT_NUM: pulse `sel_err` and stay in IDLE.
    - Otherwise stay in IDLE.
  - HDR
    - `out_valid` = !`fifo_empty[cur_port]`, `out_sop`=1, `out_data` = head of `cur_port`.
    - On transfer, load `remain` = header[7:0].
    - If N=0: assert `out_eop` on this same beat and go to DONE. Otherwise go to PAY.
  - PAY
    - `out_valid` = !`fifo_empty[cur_port]`, `out_sop`=0, `out_eop` = (`remain`==1).
    - On transfer, decrement `remain`; if `remain` was 1, go to DONE.
  - DONE
    - `pkt_done`=1 and `pkt_count` increments.
    - Next cycle: IDLE.
- Changes on `fifo_sel_res_final` are ignored outside IDLE. The lock is held until eop, so the upstream selection may change freely mid-packet.
- `out_valid` never asserts in IDLE or DONE.
- An empty locked FIFO mid-packet stalls the transfer (`out_valid`=0) with no timeout and no state change.
- `remain` is 8-bit unsigned and never underflows.

## Timing
- Reset values: `out_valid`=0, `out_sop`=0, `out_eop`=0, `fifo_rd_en`=0, `busy`=0, `cur_port`=0, `pkt_done`=0, `sel_err`=0, `pkt_count`=0, state=IDLE, `remain`=0.
- Reset applied mid-packet returns the block to IDLE on the next edge. The partial packet is abandoned (no eop) and the words left in the FIFO are not popped.
- `out_data`, `out_sop`, `out_eop` and `out_valid` are combinational from the state, `cur_port` and the FIFO head (FWFT path). `fifo_rd_en` is combinational from `out_valid & out_ready`.
- Latency: selection valid in cycle C, so the lock happens at the edge ending C and the header appears with `out_valid`=1 in cycle C+1 (FIFO non-empty).
- Throughput: 1 beat/cycle while ready and non-empty. The per-packet overhead is 2 idle cycles (DONE and IDLE) before the next header.
- `pkt_done` and the `pkt_count` increment occur in the cycle after the eop transfer. `busy` is high in HDR, PAY and DONE.
- `out_ready` low holds `out_data` and `out_valid` stable (FIFO not popped).

## Test plan
- Port 2 holds header N=3 plus 3 payload words; sel=8'h82; `out_ready`=1. Required: 4 consecutive beats from C+1, sop on beat 0, eop on beat 3, `fifo_rd_en`=4'b0100 for 4 cycles, `pkt_done` 1 cycle later, `pkt_count`=1.
- Header N=0 on port 0, sel=8'h80. Required: a single beat with sop=eop=1, then DONE, then IDLE.
- N=2 packet with `out_ready` toggling 1,0,0,1,1 and FIFO port 1 going empty for 2 cycles mid-packet. Required: no duplicated or dropped words, `fifo_rd_en` only on accepted beats, eop on the 3rd accepted beat.
- Sel switches from 8'h81 to 8'h83 in the cycle after the lock. Required: the whole packet comes from port 1; port 3 is served only after return to IDLE.
- sel=8'h85 with PORT_NUM=4. Required: `sel_err` pulses once per cycle the code is held, `busy` stays 0 and no `fifo_rd_en`. Separately, `glb_reset`=1 during PAY. Required: all outputs reach their reset values at the next edge.

Source files
------------

// File: rtl/fifo_pkt_drain.sv
// Locks onto the FIFO named by a valid selection code and forwards one length-framed
// packet (header[7:0] = payload word count) to a valid/ready output stream.
module fifo_pkt_drain #(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                         glb_clk,
    input  logic                         glb_reset,
    input  logic [7:0]                   fifo_sel_res_final,
    input  logic [PORT_NUM-1:0]          fifo_empty,
    input  logic [PORT_NUM*DATA_W-1:0]   fifo_dout,
    output logic [PORT_NUM-1:0]          fifo_rd_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         busy,
    output logic [6:0]                   cur_port,
    output logic                         pkt_done,
    output logic                         sel_err,
    output logic [15:0]                  pkt_count
);

    localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cur_port_q, cur_port_d;
    logic [7:0]  remain_q, remain_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        sel_err_q, sel_err_d;

    logic [DATA_W-1:0] head [PORT_NUM];
    logic [DATA_W-1:0] head_cur;
    logic              empty_cur;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cur_idx;
    logic              sel_valid;
    logic              sel_in_range;
    logic              xfer;

    always_comb begin
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            head[i] = fifo_dout[i*DATA_W +: DATA_W];
        end
    end

    assign sel_valid    = fifo_sel_res_final[7];
    assign sel_in_range = ({25'd0, fifo_sel_res_final[6:0]} < PORT_NUM);
    assign sel_idx      = fifo_sel_res_final[IDX_W-1:0];
    assign cur_idx      = cur_port_q[IDX_W-1:0];
    assign head_cur     = head[cur_idx];
    assign empty_cur    = fifo_empty[cur_idx];

    // Output framing is combinational from the FWFT head so a word can move every cycle.
    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = head_cur;
        unique case (state_q)
            ST_HDR: begin
                out_valid = !empty_cur;
                out_sop   = 1'b1;
                out_eop   = (head_cur[7:0] == 8'd0);
            end
            ST_PAY: begin
                out_valid = !empty_cur;
                out_eop   = (remain_q == 8'd1);
            end
            default: ;
        endcase
    end

    assign xfer = out_valid & out_ready;

    always_comb begin
        fifo_rd_en = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            fifo_rd_en[i] = xfer && (cur_idx == IDX_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_port_d  = cur_port_q;
        remain_d    = remain_q;
        pkt_count_d = pkt_count_q;
        sel_err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_valid && !sel_in_range) begin
                    sel_err_d = 1'b1;
                end else if (sel_valid && !fifo_empty[sel_idx]) begin
                    cur_port_d = fifo_sel_res_final[6:0];
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    remain_d = head_cur[7:0];
                    state_d  = out_eop ? ST_DONE : ST_PAY;
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    if (remain_q != 8'd0) begin
                        remain_d = remain_q - 8'd1;
                    end
                    if (out_eop) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Count on the eop beat so the new value is visible alongside pkt_done.
        if (xfer && out_eop) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge glb_clk) begin
        if (glb_reset) begin
            state_q     <= ST_IDLE;
            cur_port_q  <= '0;
            remain_q    <= '0;
            pkt_count_q <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_port_q  <= cur_port_d;
            remain_q    <= remain_d;
            pkt_count_q <= pkt_count_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign pkt_done  = (state_q == ST_DONE);
    assign cur_port  = cur_port_q;
    assign sel_err   = sel_err_q;
    assign pkt_count = pkt_count_q;

endmodule
